// File: rtl/bitfill.sv
// Serial pop-count-to-mask builder: turns a K-bit count into an N-bit word
// holding that many 1s, packed at the LSB end (msb_mode=0) or the MSB end (msb_mode=1).
module bitfill #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] B,
  input  logic         B_en,
  input  logic         msb_mode,
  output logic         busy,
  output logic [N-1:0] A,
  output logic         A_valid,
  output logic         ovf
);

  // Handshake: B_en is a request honoured only while busy=0 (IDLE); B and
  // msb_mode are captured on that edge. A_valid is a one-cycle pulse with A
  // and ovf valid alongside it; there is no back-pressure on the result.

  localparam int SW = $clog2(N + 1);
  localparam int CW = (K > SW) ? K : SW;
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [SW-1:0]  step_q, step_d;
  logic [K-1:0]   ones_q, ones_d;
  logic           ovf_r_q, ovf_r_d;
  logic           mode_q, mode_d;
  logic [N-1:0]   a_q, a_d;
  logic           a_valid_q, a_valid_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;

  logic [CW-1:0]  step_ext, ones_ext;
  logic           in_bit, b_over;

  assign step_ext = CW'(step_q);
  assign ones_ext = CW'(ones_q);
  assign b_over   = CW'(B) > N_C;
  // MSB mode emits its 1s during the last ones_r shifts so they end up on top.
  assign in_bit   = mode_q ? (step_ext >= (N_C - ones_ext)) : (step_ext < ones_ext);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    step_d    = step_q;
    ones_d    = ones_q;
    ovf_r_d   = ovf_r_q;
    mode_d    = mode_q;
    a_d       = a_q;
    a_valid_d = 1'b0;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (B_en) begin
          ones_d  = b_over ? K'(N) : B;
          ovf_r_d = b_over;
          mode_d  = msb_mode;
          sr_d    = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d   = {in_bit, sr_q[N-1:1]};
        step_d = step_q + SW'(1);
        if (step_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        a_d       = sr_q;
        ovf_d     = ovf_r_q;
        a_valid_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      step_q    <= '0;
      ones_q    <= '0;
      ovf_r_q   <= 1'b0;
      mode_q    <= 1'b0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      step_q    <= step_d;
      ones_q    <= ones_d;
      ovf_r_q   <= ovf_r_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign A       = a_q;
  assign A_valid = a_valid_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bitfill.sv
// Randomized bench for bitfill (N=8, K=4) with a bit-placement reference model
// and an expected-result queue.
module tb_bitfill;

  localparam int N = 8;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [K-1:0] B = '0;
  logic         B_en = 1'b0;
  logic         msb_mode = 1'b0;
  logic         busy;
  logic [N-1:0] A;
  logic         A_valid;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];
  logic         exp_ovf_q[$];

  bitfill #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .B(B), .B_en(B_en), .msb_mode(msb_mode),
    .busy(busy), .A(A), .A_valid(A_valid), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: place min(b,N) ones starting at the chosen end of the word.
  function automatic logic [N-1:0] model(input int b, input bit m);
    logic [N-1:0] r;
    int n;
    n = (b > N) ? N : b;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (m) r[N-1-i] = 1'b1;
      else   r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic expect_job(input int b, input bit m);
    exp_q.push_back(model(b, m));
    exp_ovf_q.push_back(b > N);
  endtask

  // Waits on negedges for A_valid; edges = clock edges elapsed, -1 on timeout.
  task automatic wait_valid(output int edges, output int busy_n);
    edges = -1;
    busy_n = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (A_valid) begin
        edges = e;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic score(input string tag);
    logic [N-1:0] ea;
    logic         eo;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_valid"}, 1, 0);
      return;
    end
    ea = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    check({tag, "_A"}, 32'(A), 32'(ea));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_popcount"}, $countones(A), $countones(ea));
  endtask

  // driver: one job, optional B_en poke while busy, full timing check
  task automatic run_job(input int b, input bit m, input bit poke, input string tag);
    int edges, busy_n;
    logic [N-1:0] held;
    expect_job(b, m);
    @(negedge clk);
    B = K'(b); msb_mode = m; B_en = 1'b1;
    @(negedge clk);
    B_en = 1'b0;
    B = K'($urandom); msb_mode = 1'($urandom);
    check({tag, "_busy_after_accept"}, 32'(busy), 1);
    edges = -1;
    busy_n = 1;
    for (int e = 1; e <= 40; e++) begin
      if (poke && e == 3) begin B = K'($urandom); msb_mode = 1'($urandom); B_en = 1'b1; end
      if (poke && e == 4) B_en = 1'b0;
      @(negedge clk);
      if (A_valid) begin edges = e; break; end
      if (busy) busy_n++;
    end
    if (edges < 0) begin
      check({tag, "_timeout"}, 1, 0);
      void'(exp_q.pop_front());
      void'(exp_ovf_q.pop_front());
      return;
    end
    check({tag, "_latency"}, 32'(edges), N + 1);
    check({tag, "_busy_cycles"}, 32'(busy_n), N + 1);
    check({tag, "_busy_at_valid"}, 32'(busy), 0);
    score(tag);
    held = A;
    @(negedge clk);
    check({tag, "_valid_pulse"}, 32'(A_valid), 0);
    check({tag, "_A_held"}, 32'(A), 32'(held));
  endtask

  initial begin
    int edges, busy_n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_A", 32'(A), 0);
    check("reset_valid", 32'(A_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_ovf", 32'(ovf), 0);

    // directed cases
    run_job(3, 0, 0, "b3_lsb");
    run_job(5, 1, 0, "b5_msb");
    run_job(0, 0, 0, "b0_lsb");
    run_job(0, 1, 0, "b0_msb");
    run_job(8, 0, 0, "b8");
    run_job(12, 0, 0, "b12_sat");
    run_job(1, 0, 0, "b1_after_sat");
    run_job(15, 1, 1, "b15_msb_poke");

    // B_en held: B changes during SHIFT, next job taken on the A_valid edge
    expect_job(2, 0);
    expect_job(7, 0);
    @(negedge clk);
    B = 4'd2; msb_mode = 1'b0; B_en = 1'b1;
    @(negedge clk);
    B = 4'd7;
    wait_valid(edges, busy_n);
    check("held_first_latency", 32'(edges), N + 1);
    score("held_first");
    wait_valid(edges, busy_n);
    B_en = 1'b0;
    check("held_second_spacing", 32'(edges), N + 2);
    if (edges > 0) score("held_second");
    repeat (2 * N) @(negedge clk);
    check("held_no_third_job", 32'(busy), 0);
    exp_q.delete();
    exp_ovf_q.delete();

    // reset mid-job at step 4
    @(negedge clk);
    B = 4'd6; msb_mode = 1'b0; B_en = 1'b1;
    @(negedge clk);
    B_en = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_A", 32'(A), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_ovf", 32'(ovf), 0);
    wait_valid(edges, busy_n);
    check("midreset_no_valid", 32'(edges), 32'(-1));
    run_job(4, 0, 0, "after_reset_b4");

    // round trip: popcount of the result recovers the count
    for (int m = 0; m < 2; m++)
      for (int b = 0; b <= N; b++)
        run_job(b, 1'(m), 0, $sformatf("round_b%0d_m%0d", b, m));

    // random jobs
    for (int i = 0; i < 25; i++)
      run_job($urandom_range(0, 15), 1'($urandom), 1'($urandom_range(0, 1)),
              $sformatf("rand%0d", i));

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
